// File: rtl/ssd1306_spi4_tx_if.sv
// Byte-stream handshake into the SSD1306 SPI transmitter.
// Each byte carries a D/C# tag: 0 = command, 1 = data.
interface ssd1306_spi4_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dc;

  modport master (output in_valid, output in_data, output in_dc, input in_ready);
  modport slave  (input in_valid, input in_data, input in_dc, output in_ready);
endinterface

// File: rtl/ssd1306_spi4_tx.sv
// 4-wire SPI (mode 0, MSB first) transmitter for SSD1306-style controllers.
// A small {dc,data} FIFO feeds a shifter that keeps CS# low across queued bytes.
module ssd1306_spi4_tx #(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ssd1306_spi4_tx_if.slave  in_bus,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_sdi,
  output logic              spi_dc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    HOLD     = 3'd4
  } state_t;

  logic [8:0]    mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [8:0]    head_s;

  state_t        state_r;
  state_t        next_state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          cnt_done_s;
  logic [2:0]    bitcnt_r;
  logic [2:0]    bitcnt_nxt_s;
  // Holds the bits still to be sent after the one currently on SDI.
  logic [6:0]    shreg_r;
  logic [6:0]    shreg_nxt_s;
  logic          cs_nxt_s;
  logic          sck_nxt_s;
  logic          sdi_nxt_s;
  logic          dc_nxt_s;

  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
  assign push_s     = in_bus.in_valid && !full_s;
  assign in_bus.in_ready = !full_s;
  assign busy       = !empty_s || (state_r != IDLE);
  assign cnt_done_s = (cnt_r == CNT_LAST);

  // FIFO storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {in_bus.in_dc, in_bus.in_data};
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
    end
  end

  // Next-state and datapath decode for the serialiser.
  always_comb begin
    next_state_s = state_r;
    cnt_nxt_s    = cnt_r;
    bitcnt_nxt_s = bitcnt_r;
    shreg_nxt_s  = shreg_r;
    cs_nxt_s     = spi_cs_n;
    sck_nxt_s    = spi_sck;
    sdi_nxt_s    = spi_sdi;
    dc_nxt_s     = spi_dc;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s        = 1'b1;
          shreg_nxt_s  = head_s[6:0];
          sdi_nxt_s    = head_s[7];
          dc_nxt_s     = head_s[8];
          cs_nxt_s     = 1'b0;
          bitcnt_nxt_s = 3'd0;
          cnt_nxt_s    = '0;
          next_state_s = SETUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_done_s) begin
          cnt_nxt_s    = '0;
          sck_nxt_s    = 1'b1;
          next_state_s = SHIFT_HI;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1'b1);
        end
      end
      SHIFT_HI: begin
        if (cnt_done_s) begin
          cnt_nxt_s    = '0;
          sck_nxt_s    = 1'b0;
          sdi_nxt_s    = shreg_r[6];
          shreg_nxt_s  = {shreg_r[5:0], 1'b0};
          next_state_s = SHIFT_LO;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1'b1);
        end
      end
      SHIFT_LO: begin
        if (cnt_done_s) begin
          cnt_nxt_s = '0;
          if (bitcnt_r != 3'd7) begin
            bitcnt_nxt_s = bitcnt_r + 3'd1;
            sck_nxt_s    = 1'b1;
            next_state_s = SHIFT_HI;
          end else if (!empty_s) begin
            // Chain the next byte straight onto the wire with CS# held low.
            pop_s        = 1'b1;
            shreg_nxt_s  = head_s[6:0];
            sdi_nxt_s    = head_s[7];
            dc_nxt_s     = head_s[8];
            bitcnt_nxt_s = 3'd0;
            sck_nxt_s    = 1'b1;
            next_state_s = SHIFT_HI;
          end else begin
            next_state_s = HOLD;
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1'b1);
        end
      end
      HOLD: begin
        if (cnt_done_s) begin
          cnt_nxt_s    = '0;
          cs_nxt_s     = 1'b1;
          next_state_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        next_state_s = IDLE;
        cs_nxt_s     = 1'b1;
        sck_nxt_s    = 1'b0;
      end
    endcase
  end

  // State and registered SPI pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      bitcnt_r <= 3'd0;
      shreg_r  <= 7'd0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_sdi  <= 1'b0;
      spi_dc   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      cnt_r    <= cnt_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      shreg_r  <= shreg_nxt_s;
      spi_cs_n <= cs_nxt_s;
      spi_sck  <= sck_nxt_s;
      spi_sdi  <= sdi_nxt_s;
      spi_dc   <= dc_nxt_s;
    end
  end

endmodule

// File: tb/tb_ssd1306_spi4_tx.sv
// Bench for ssd1306_spi4_tx: two instances (CLK_DIV 2 and 1) with a receiver model
// that rebuilds {dc,byte} from the SPI pins and checks it against a FIFO of sent bytes.
module tb_ssd1306_spi4_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  logic       in_valid_t [2];
  logic [7:0] in_data_t  [2];
  logic       in_dc_t    [2];
  logic       rdy    [2];
  logic       busy_w [2];
  logic       cs_w   [2];
  logic       sck_w  [2];
  logic       sdi_w  [2];
  logic       dc_w   [2];

  ssd1306_spi4_tx_if bus0 ();
  ssd1306_spi4_tx_if bus1 ();

  assign bus0.in_valid = in_valid_t[0];
  assign bus0.in_data  = in_data_t[0];
  assign bus0.in_dc    = in_dc_t[0];
  assign rdy[0]        = bus0.in_ready;
  assign bus1.in_valid = in_valid_t[1];
  assign bus1.in_data  = in_data_t[1];
  assign bus1.in_dc    = in_dc_t[1];
  assign rdy[1]        = bus1.in_ready;

  ssd1306_spi4_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus0), .busy(busy_w[0]),
    .spi_cs_n(cs_w[0]), .spi_sck(sck_w[0]), .spi_sdi(sdi_w[0]), .spi_dc(dc_w[0])
  );

  ssd1306_spi4_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus1), .busy(busy_w[1]),
    .spi_cs_n(cs_w[1]), .spi_sck(sck_w[1]), .spi_sdi(sdi_w[1]), .spi_dc(dc_w[1])
  );

  // Expected {dc,data} in acceptance order, one queue per instance.
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int qsize(input int g);
    return (g == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Receiver model state.
  logic       p_cs  [2];
  logic       p_sck [2];
  logic       p_sdi [2];
  logic       p_dc  [2];
  int         bits  [2];
  logic [7:0] sh    [2];
  logic       dcb   [2];
  longint     last_rise [2];
  longint     last_fall [2];
  logic       rise_ok   [2];
  int         rises  [2] = '{0, 0};
  int         bursts [2] = '{0, 0};
  longint     cyc = 0;
  int         div_m;
  logic [8:0] want_m;

  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      div_m = (g == 0) ? 2 : 1;
      if (!rst_n) begin
        p_cs[g] = 1'b1; p_sck[g] = 1'b0; p_sdi[g] = 1'b0; p_dc[g] = 1'b0;
        bits[g] = 0; rise_ok[g] = 1'b0;
        if (g == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        if (sck_w[g] != p_sck[g]) chk("sck_toggle_cs_low", int'(cs_w[g]), 0);
        if (!cs_w[g] && (sdi_w[g] != p_sdi[g] || dc_w[g] != p_dc[g]))
          chk("sdi_dc_change_sck_low", int'(p_sck[g] && sck_w[g]), 0);
        if (!p_sck[g] && sck_w[g]) begin
          if (rise_ok[g]) chk("rise_interval", int'(cyc - last_rise[g]), 2 * div_m);
          rise_ok[g]   = 1'b1;
          last_rise[g] = cyc;
          rises[g]++;
          if (bits[g] == 0) dcb[g] = dc_w[g];
          else chk("dc_stable_in_byte", int'(dc_w[g]), int'(dcb[g]));
          sh[g] = {sh[g][6:0], sdi_w[g]};
          bits[g]++;
          if (bits[g] == 8) begin
            bits[g] = 0;
            if (qsize(g) == 0) begin
              tests++;
              fails++;
              $display("FAIL rx_unexpected_byte: got 0x%0h expected none (dut%0d)", {dcb[g], sh[g]}, g);
            end else begin
              want_m = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk("rx_byte", int'({dcb[g], sh[g]}), int'(want_m));
            end
          end
        end
        if (p_sck[g] && !sck_w[g]) last_fall[g] = cyc;
        if (p_cs[g] && !cs_w[g]) begin
          bursts[g]++;
          rise_ok[g] = 1'b0;
        end
        if (!p_cs[g] && cs_w[g]) begin
          chk("cs_rise_after_last_fall", int'(cyc - last_fall[g]), 2 * div_m);
          chk("cs_rise_byte_aligned", bits[g], 0);
        end
        p_cs[g] = cs_w[g]; p_sck[g] = sck_w[g]; p_sdi[g] = sdi_w[g]; p_dc[g] = dc_w[g];
      end
    end
  end

  // Offer one byte; called just after a falling clk edge.
  task automatic send(input int g, input logic dc, input logic [7:0] d);
    int t;
    t = 0;
    in_valid_t[g] = 1'b1;
    in_dc_t[g]    = dc;
    in_data_t[g]  = d;
    while (!rdy[g] && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[g]) begin
      tests++;
      fails++;
      $display("FAIL send_ready_timeout: got in_ready=0 expected 1 (dut%0d)", g);
      in_valid_t[g] = 1'b0;
    end else begin
      if (g == 0) exp_q0.push_back({dc, d}); else exp_q1.push_back({dc, d});
      @(negedge clk);
      in_valid_t[g] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int g);
    int t;
    t = 0;
    @(negedge clk); #1;
    while ((busy_w[g] || !cs_w[g] || qsize(g) != 0) && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("idle_reached", int'(t < 3000), 1);
    chk("busy_low_when_idle", int'(busy_w[g]), 0);
    chk("queue_drained", qsize(g), 0);
  endtask

  task automatic chk_reset_pins(input int g);
    chk("rst_cs_n", int'(cs_w[g]), 1);
    chk("rst_sck", int'(sck_w[g]), 0);
    chk("rst_sdi", int'(sdi_w[g]), 0);
    chk("rst_dc", int'(dc_w[g]), 0);
    chk("rst_busy", int'(busy_w[g]), 0);
    chk("rst_in_ready", int'(rdy[g]), 1);
  endtask

  int b0;
  int r0;
  int t0;
  int nb;

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      in_valid_t[g] = 1'b0; in_data_t[g] = 8'h00; in_dc_t[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_reset_pins(0);
    chk_reset_pins(1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single command byte.
    send(0, 1'b0, 8'hA5);
    wait_idle(0);

    // Command then two data bytes in one CS# frame.
    b0 = bursts[0];
    send(0, 1'b0, 8'hAF);
    send(0, 1'b1, 8'h3C);
    send(0, 1'b1, 8'hFF);
    wait_idle(0);
    chk("three_bytes_one_frame", bursts[0] - b0, 1);

    // Fill the FIFO with in_valid held.
    b0 = bursts[0];
    for (int i = 0; i < 5; i++) send(0, 1'(i & 1), 8'(8'h10 + i));
    chk("ready_low_when_full", int'(rdy[0]), 0);
    send(0, 1'b0, 8'h99);
    wait_idle(0);
    chk("six_bytes_one_frame", bursts[0] - b0, 1);

    // Reset mid-byte after the 3rd rising SCK edge.
    r0 = rises[0];
    send(0, 1'b0, 8'h81);
    t0 = 0;
    while (rises[0] < r0 + 3 && t0 < 200) begin
      @(negedge clk); #1;
      t0++;
    end
    chk("third_edge_seen", int'(rises[0] >= r0 + 3), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midbyte_rst_cs_n", int'(cs_w[0]), 1);
    chk("midbyte_rst_sck", int'(sck_w[0]), 0);
    chk("midbyte_rst_busy", int'(busy_w[0]), 0);
    chk("midbyte_rst_ready", int'(rdy[0]), 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(0, 1'b1, 8'h55);
    wait_idle(0);

    // CLK_DIV=1 instance: two bytes, 2-cycle SCK period checked by the monitor.
    b0 = bursts[1];
    r0 = rises[1];
    send(1, 1'b0, 8'h00);
    send(1, 1'b0, 8'hFF);
    wait_idle(1);
    chk("div1_one_frame", bursts[1] - b0, 1);
    chk("div1_sixteen_edges", rises[1] - r0, 16);

    // Push during the last SCK-low phase of a byte: no CS# gap.
    b0 = bursts[0];
    r0 = rises[0];
    send(0, 1'b0, 8'h3A);
    t0 = 0;
    while (!(rises[0] >= r0 + 8 && !sck_w[0]) && t0 < 200) begin
      @(negedge clk); #1;
      t0++;
    end
    chk("last_low_phase_seen", int'(t0 < 200), 1);
    send(0, 1'b1, 8'hC6);
    wait_idle(0);
    chk("late_push_gapless", bursts[0] - b0, 1);

    // Randomised traffic on both instances.
    for (int n = 0; n < 30; n++) begin
      nb = int'($urandom_range(1, 4));
      for (int k = 0; k < nb; k++) begin
        send(n & 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 2) == 0) repeat (int'($urandom_range(1, 30))) @(negedge clk);
      end
      if ($urandom_range(0, 3) == 0) wait_idle(n & 1);
    end
    wait_idle(0);
    wait_idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
